// File: rtl/ps_filter_sequencer.sv
// Frame-level controller for the filter stage: counts pixels and changes the filter mode
// only between frames, holding FIFO reads while the pipeline drains and is flushed.
module ps_filter_sequencer #(
  parameter int FRAME_W      = 640,
  parameter int FRAME_H      = 480,
  parameter int DRAIN_CYCLES = 16,
  parameter int FLUSH_CYCLES = 4,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_mode_req,
  input  logic                   i_mode_req_valid,
  input  logic                   i_resync,
  input  logic                   i_in_valid,
  input  logic                   i_out_valid,
  output logic                   o_enable,
  output logic                   o_flush,
  output logic                   o_hold,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic                   o_err
);

  localparam int TOTAL   = FRAME_W * FRAME_H;
  localparam int PIX_W   = $clog2(TOTAL + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(TOTAL - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]             state_q,      state_d;
  logic [PIX_W-1:0]       pix_cnt_q,    pix_cnt_d;
  logic [DRAIN_W-1:0]     idle_cnt_q,   idle_cnt_d;
  logic [FLUSH_W-1:0]     flush_cnt_q,  flush_cnt_d;
  logic                   pend_q,       pend_d;
  logic                   pend_vld_q,   pend_vld_d;
  logic                   enable_q,     enable_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q,  frame_cnt_d;
  logic                   err_q,        err_d;
  logic                   flush_entry;
  logic                   last_px;

  // The final pixel must stop the very next registered FIFO read, so hold is combinational.
  assign last_px = (state_q == ST_RUN) && i_in_valid && (pix_cnt_q == PIX_LAST);

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q | (i_in_valid && (state_q != ST_RUN));
    flush_entry  = 1'b0;

    if (i_resync) begin
      state_d     = ST_FLUSH;
      pix_cnt_d   = '0;
      idle_cnt_d  = '0;
      flush_cnt_d = '0;
      flush_entry = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (last_px) begin
            pix_cnt_d  = '0;
            idle_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else if (i_in_valid) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (i_out_valid) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == DRAIN_LAST) begin
            state_d      = ST_FLUSH;
            idle_cnt_d   = '0;
            flush_cnt_d  = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
            flush_entry  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + DRAIN_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
            pix_cnt_d   = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    // A strobe arriving on the FLUSH-entry cycle bypasses the pending register.
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    enable_d   = enable_q;
    if (flush_entry) begin
      if (i_mode_req_valid)  enable_d = i_mode_req;
      else if (pend_vld_q)   enable_d = pend_q;
      pend_vld_d = 1'b0;
    end else if (i_mode_req_valid) begin
      pend_d     = i_mode_req;
      pend_vld_d = 1'b1;
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge); state uses non-blocking assignment.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= ST_RUN;
      pix_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      pend_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign o_enable     = enable_q;
  assign o_flush      = (state_q == ST_FLUSH);
  assign o_hold       = (state_q != ST_RUN) || last_px;
  assign o_busy       = (state_q != ST_RUN);
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_err        = err_q;

endmodule
